// File: rtl/frame_dump_seq.sv
// Frame dump sequencer: on a debounced trigger, reads the downsample buffer in raster
// order and streams each 32-bit word MSB-first to a UART. Define FRAME_DUMP_HEADER_EN for an 0xA5,0x5A preamble.
module frame_dump_seq #(
    parameter int WIDTH         = 40,
    parameter int HEIGHT        = 30,
    parameter int DEBOUNCE_BITS = 14,
    parameter int HOLDOFF_BITS  = 13
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        trigger_i,
    output logic [5:0]  rd_x_o,
    output logic [4:0]  rd_y_o,
    input  logic [31:0] rd_q_i,
    input  logic        uart_busy_i,
    output logic        uart_wr_o,
    output logic [7:0]  uart_dat_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_WAIT   = 3'd3,
        S_STROBE = 3'd4,
`ifdef FRAME_DUMP_HEADER_EN
        S_HDR    = 3'd6,
`endif
        S_DONE   = 3'd5
    } state_t;

    localparam logic [5:0] X_LAST = 6'(WIDTH - 1);
    localparam logic [4:0] Y_LAST = 5'(HEIGHT - 1);
    localparam logic [DEBOUNCE_BITS-1:0] DEB_ONE  = 1;
    localparam logic [HOLDOFF_BITS-1:0]  HOLD_ONE = 1;

    state_t                    state_q, state_d;
    logic                      trig_meta_q, trig_sync_q;
    logic [DEBOUNCE_BITS-1:0]  deb_q;
    logic [HOLDOFF_BITS-1:0]   hold_q;
    logic [5:0]                x_q;
    logic [4:0]                y_q;
    logic [1:0]                z_q;
    logic [31:0]               word_q;
    logic [7:0]                dat_q;
    logic                      start;
    logic                      last_word;
    logic                      can_send;
`ifdef FRAME_DUMP_HEADER_EN
    logic                      hdr_q;
    logic                      hdr_sent_q;
`endif

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    pick_byte = w[31:24];
            2'd1:    pick_byte = w[23:16];
            2'd2:    pick_byte = w[15:8];
            default: pick_byte = w[7:0];
        endcase
    endfunction

    // The counter clears while the trigger is high, so a held button cannot restart a dump.
    assign start     = (state_q == S_IDLE) && trig_sync_q && (&deb_q);
    assign last_word = (x_q == X_LAST) && (y_q == Y_LAST);
    // UART handshake: a byte is offered by a one-cycle uart_wr_o pulse only when
    // uart_busy_i is low and the holdoff counter has saturated since the last pulse or busy.
    assign can_send  = (&hold_q) && !uart_busy_i && !uart_wr_o;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        uart_wr_o = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef FRAME_DUMP_HEADER_EN
                    state_d = S_HDR;
`else
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef FRAME_DUMP_HEADER_EN
            S_HDR:   state_d = S_WAIT;
`endif
            S_FETCH: state_d = S_LATCH;
            S_LATCH: state_d = S_WAIT;
            S_WAIT: begin
                if (can_send) state_d = S_STROBE;
            end
            S_STROBE: begin
                uart_wr_o = 1'b1;
`ifdef FRAME_DUMP_HEADER_EN
                if (hdr_q) state_d = hdr_sent_q ? S_FETCH : S_HDR;
                else
`endif
                if (z_q != 2'd3)    state_d = S_WAIT;
                else if (last_word) state_d = S_DONE;
                else                state_d = S_FETCH;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            trig_meta_q <= 1'b0;
            trig_sync_q <= 1'b0;
            deb_q       <= '0;
            hold_q      <= '0;
        end else begin
            trig_meta_q <= trigger_i;
            trig_sync_q <= trig_meta_q;
            if (trig_sync_q)  deb_q <= '0;
            else if (~&deb_q) deb_q <= deb_q + DEB_ONE;
            if (uart_busy_i || uart_wr_o) hold_q <= '0;
            else if (~&hold_q)            hold_q <= hold_q + HOLD_ONE;
        end
    end

    // Address only moves on start or the final byte of a word, keeping rd_q_i stable for LATCH.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            word_q     <= '0;
            dat_q      <= '0;
`ifdef FRAME_DUMP_HEADER_EN
            hdr_q      <= 1'b0;
            hdr_sent_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q <= '0;
                        y_q <= '0;
                        z_q <= '0;
`ifdef FRAME_DUMP_HEADER_EN
                        hdr_q      <= 1'b1;
                        hdr_sent_q <= 1'b0;
`endif
                    end
                end
`ifdef FRAME_DUMP_HEADER_EN
                S_HDR: dat_q <= hdr_sent_q ? 8'h5A : 8'hA5;
`endif
                S_LATCH: begin
                    word_q <= rd_q_i;
                    dat_q  <= rd_q_i[31:24];
                end
                S_STROBE: begin
`ifdef FRAME_DUMP_HEADER_EN
                    if (hdr_q) begin
                        if (hdr_sent_q) hdr_q <= 1'b0;
                        else            hdr_sent_q <= 1'b1;
                    end else
`endif
                    if (z_q != 2'd3) begin
                        z_q   <= z_q + 2'd1;
                        dat_q <= pick_byte(word_q, z_q + 2'd1);
                    end else if (!last_word) begin
                        z_q <= '0;
                        if (x_q == X_LAST) begin
                            x_q <= '0;
                            y_q <= y_q + 5'd1;
                        end else begin
                            x_q <= x_q + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_x_o      = x_q;
    assign rd_y_o      = y_q;
    assign uart_dat_o  = dat_q;
    assign busy_o      = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule
